// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU control sequencer.
//   - opcode encodings for the two-bit instruction opcode field
//   - sequencer state enum
//   - instruction field offsets and counter width, derived from the array
//     dimension and the operand width
package tpu_pkg;

   localparam logic [1:0] OP_START = 2'b00;
   localparam logic [1:0] OP_STOP  = 2'b01;
   localparam logic [1:0] OP_LOAD  = 2'b10;
   localparam logic [1:0] OP_STORE = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Instruction layout, LSB first: imm | col | row | reserved | mode | opcode
   function automatic int col_lsb(input int data_width);
      return data_width;
   endfunction

   function automatic int row_lsb(input int n, input int data_width);
      return data_width + $clog2(n);
   endfunction

   function automatic int rsv_bit(input int n, input int data_width);
      return data_width + 2*$clog2(n);
   endfunction

   function automatic int mode_bit(input int n, input int data_width);
      return rsv_bit(n, data_width) + 1;
   endfunction

   function automatic int op_lsb(input int n, input int data_width);
      return rsv_bit(n, data_width) + 2;
   endfunction

   // Wide enough that the run counter reaches the end of drain without wrapping.
   function automatic int cnt_width(input int n, input int drain_cycles);
      return $clog2(2*n + drain_cycles + 1);
   endfunction

endpackage

// File: rtl/tpu_skew_gen.sv
// Skewed operand-feed decoder for an N-line systolic array.
// Ports:
//   counter     in   run counter (registered in the sequencer)
//   read_enable out  N bits, line i active while i+1 <= counter <= i+N
//   read_elem   out  N*IDX_W bits, line i at [i*IDX_W +: IDX_W];
//                    counter-(i+1) inside the window, 0 outside
// Purely combinational from the counter so both memories see the same
// schedule with no dependence on the incoming instruction.
module tpu_skew_gen
   import tpu_pkg::*;
#(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N),
   parameter int CNT_W = cnt_width(N, N)
) (
   input  logic [CNT_W-1:0]   counter,
   output logic [N-1:0]       read_enable,
   output logic [N*IDX_W-1:0] read_elem
);

   always_comb begin
      read_enable = '0;
      read_elem   = '0;
      for (int i = 0; i < N; i++) begin
         if ((counter >= CNT_W'(i+1)) && (counter <= CNT_W'(i+N))) begin
            read_enable[i]               = 1'b1;
            read_elem[i*IDX_W +: IDX_W]  = IDX_W'(counter - CNT_W'(i+1));
         end
      end
   end

endmodule

// File: rtl/tpu_sequencer.sv
// Control sequencer for the NxN systolic-array TPU.
// Accepts instructions over valid/ready; LOAD writes operand memory A or B,
// STORE selects the array readout row/column, START runs the skewed feed
// followed by a drain phase and a done pulse, STOP aborts a run.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   instr_valid/instr_ready  instruction handshake
//   instruction              {opcode, mode/mem_select, reserved, row, col, imm}
//   busy, done, aborted      run status and one-cycle completion/abort pulses
//   array_write_enable       array compute enable (RUN and DRAIN)
//   array_clear              one-cycle accumulator clear at start of a run
//   array_output_row/column  readout select
//   mem{a,b}_*               write port and skewed per-line read controls
//
// state | meaning
// IDLE  | accepts every instruction; LOAD/STORE/START decoded here
// RUN   | feed phase, counter 0..2N-1; only STOP accepted
// DRAIN | array settling for DRAIN_CYCLES; only STOP accepted
module tpu_sequencer
   import tpu_pkg::*;
#(
   parameter int N            = 4,
   parameter int DATA_WIDTH   = 8,
   parameter int IDX_W        = $clog2(N),
   parameter int INSTR_W      = 4 + 2*IDX_W + DATA_WIDTH,
   parameter int DRAIN_CYCLES = N
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  instr_valid,
   output logic                  instr_ready,
   input  logic [INSTR_W-1:0]    instruction,
   output logic                  busy,
   output logic                  done,
   output logic                  aborted,
   output logic                  array_write_enable,
   output logic                  array_clear,
   output logic [IDX_W-1:0]      array_output_row,
   output logic [IDX_W-1:0]      array_output_column,
   output logic [DATA_WIDTH-1:0] mema_data_in,
   output logic                  mema_write_enable,
   output logic [IDX_W-1:0]      mema_write_line,
   output logic [IDX_W-1:0]      mema_write_elem,
   output logic [N-1:0]          mema_read_enable,
   output logic [N*IDX_W-1:0]    mema_read_elem,
   output logic [DATA_WIDTH-1:0] memb_data_in,
   output logic                  memb_write_enable,
   output logic [IDX_W-1:0]      memb_write_line,
   output logic [IDX_W-1:0]      memb_write_elem,
   output logic [N-1:0]          memb_read_enable,
   output logic [N*IDX_W-1:0]    memb_read_elem
);

   localparam int CNT_W    = cnt_width(N, DRAIN_CYCLES);
   localparam int OP_LSB   = op_lsb(N, DATA_WIDTH);
   localparam int MODE_BIT = mode_bit(N, DATA_WIDTH);
   localparam int RSV_BIT  = rsv_bit(N, DATA_WIDTH);
   localparam int ROW_LSB  = row_lsb(N, DATA_WIDTH);
   localparam int COL_LSB  = col_lsb(DATA_WIDTH);

   localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(2*N - 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(2*N - 1 + DRAIN_CYCLES);

   logic [1:0]            opcode;
   logic                  mode;
   logic                  unused_rsv;
   logic [IDX_W-1:0]      row;
   logic [IDX_W-1:0]      col;
   logic [DATA_WIDTH-1:0] imm;
   logic                  accept;

   state_t                state, state_nxt;
   logic [CNT_W-1:0]      counter, counter_nxt;
   logic                  done_nxt, aborted_nxt, clear_nxt;

   logic [N-1:0]          read_enable;
   logic [N*IDX_W-1:0]    read_elem;

   assign opcode     = instruction[OP_LSB +: 2];
   assign mode       = instruction[MODE_BIT];
   assign unused_rsv = instruction[RSV_BIT];
   assign row        = instruction[ROW_LSB +: IDX_W];
   assign col        = instruction[COL_LSB +: IDX_W];
   assign imm        = instruction[DATA_WIDTH-1:0];

   // STOP is let through while busy so a run can always be aborted.
   assign instr_ready = (state == IDLE) || (instr_valid && (opcode == OP_STOP));
   assign accept      = instr_valid && instr_ready;

   assign busy               = (state == RUN) || (state == DRAIN);
   assign array_write_enable = busy;

   always_comb begin
      state_nxt   = state;
      counter_nxt = counter;
      done_nxt    = 1'b0;
      aborted_nxt = 1'b0;
      clear_nxt   = 1'b0;
      case (state)
         IDLE: begin
            counter_nxt = '0;
            if (accept && (opcode == OP_START)) begin
               state_nxt = RUN;
               clear_nxt = !mode;
            end
         end
         RUN: begin
            if (accept && (opcode == OP_STOP)) begin
               state_nxt   = IDLE;
               counter_nxt = '0;
               aborted_nxt = 1'b1;
            end else begin
               counter_nxt = counter + CNT_W'(1);
               if (counter == FEED_LAST) begin
                  if (DRAIN_CYCLES == 0) begin
                     state_nxt   = IDLE;
                     counter_nxt = '0;
                     done_nxt    = 1'b1;
                  end else begin
                     state_nxt = DRAIN;
                  end
               end
            end
         end
         DRAIN: begin
            if (accept && (opcode == OP_STOP)) begin
               state_nxt   = IDLE;
               counter_nxt = '0;
               aborted_nxt = 1'b1;
            end else if (counter == DRAIN_LAST) begin
               state_nxt   = IDLE;
               counter_nxt = '0;
               done_nxt    = 1'b1;
            end else begin
               counter_nxt = counter + CNT_W'(1);
            end
         end
         default: begin
            state_nxt   = IDLE;
            counter_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         counter     <= '0;
         done        <= 1'b0;
         aborted     <= 1'b0;
         array_clear <= 1'b0;
      end else begin
         state       <= state_nxt;
         counter     <= counter_nxt;
         done        <= done_nxt;
         aborted     <= aborted_nxt;
         array_clear <= clear_nxt;
      end
   end

   // LOAD/STORE datapath; the untargeted memory keeps its last address/data.
   always_ff @(posedge clk) begin
      if (rst) begin
         mema_data_in        <= '0;
         mema_write_enable   <= 1'b0;
         mema_write_line     <= '0;
         mema_write_elem     <= '0;
         memb_data_in        <= '0;
         memb_write_enable   <= 1'b0;
         memb_write_line     <= '0;
         memb_write_elem     <= '0;
         array_output_row    <= '0;
         array_output_column <= '0;
      end else begin
         mema_write_enable <= 1'b0;
         memb_write_enable <= 1'b0;
         if (accept && (state == IDLE)) begin
            case (opcode)
               OP_LOAD: begin
                  if (!mode) begin
                     mema_data_in      <= imm;
                     mema_write_line   <= row;
                     mema_write_elem   <= col;
                     mema_write_enable <= 1'b1;
                  end else begin
                     memb_data_in      <= imm;
                     memb_write_line   <= row;
                     memb_write_elem   <= col;
                     memb_write_enable <= 1'b1;
                  end
               end
               OP_STORE: begin
                  array_output_row    <= row;
                  array_output_column <= col;
               end
               default: ;
            endcase
         end
      end
   end

   tpu_skew_gen #(
      .N     (N),
      .IDX_W (IDX_W),
      .CNT_W (CNT_W)
   ) u_skew (
      .counter     (counter),
      .read_enable (read_enable),
      .read_elem   (read_elem)
   );

   assign mema_read_enable = read_enable;
   assign memb_read_enable = read_enable;
   assign mema_read_elem   = read_elem;
   assign memb_read_elem   = read_elem;

endmodule

// File: tb/tb_tpu_sequencer.sv
// Scoreboard bench for tpu_sequencer: an N=4 instance for the detailed
// schedule and an N=8 instance for run length and mid-drain reset.
module tb_tpu_sequencer;

   localparam logic [1:0] S_OP_START = 2'b00;
   localparam logic [1:0] S_OP_STOP  = 2'b01;
   localparam logic [1:0] S_OP_LOAD  = 2'b10;
   localparam logic [1:0] S_OP_STORE = 2'b11;

   localparam int K_CLEAR = 0, K_FEED = 1, K_WRA = 2, K_WRB = 3,
                  K_DONE = 4, K_ABORT = 5, K_RSEL = 6;

   typedef struct {
      int kind;
      int cyc;
      int v0;
      int v1;
      int v2;
   } ev_t;

   ev_t sb4[$];
   ev_t sb8[$];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit mon_on   = 1'b0;

   // N=4 feed schedule, counter 1..7: line enables and packed element indices
   int feed_en[7] = '{32'h1, 32'h3, 32'h7, 32'hF, 32'hE, 32'hC, 32'h8};
   int feed_el[7] = '{32'h00, 32'h01, 32'h06, 32'h1B, 32'h6C, 32'hB0, 32'hC0};

   logic clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- N=4 instance ----------------
   logic        rst4, valid4, ready4, busy4, done4, abort4, awe4, clr4;
   logic [15:0] instr4;
   logic [1:0]  row4, col4, la4, ea4, lb4, eb4;
   logic [7:0]  da4, db4, rel4a, rel4b;
   logic        wea4, web4;
   logic [3:0]  rea4, reb4;

   tpu_sequencer #(.N(4), .DATA_WIDTH(8), .DRAIN_CYCLES(4)) dut4 (
      .clk(clk), .rst(rst4), .instr_valid(valid4), .instr_ready(ready4),
      .instruction(instr4), .busy(busy4), .done(done4), .aborted(abort4),
      .array_write_enable(awe4), .array_clear(clr4),
      .array_output_row(row4), .array_output_column(col4),
      .mema_data_in(da4), .mema_write_enable(wea4), .mema_write_line(la4),
      .mema_write_elem(ea4), .mema_read_enable(rea4), .mema_read_elem(rel4a),
      .memb_data_in(db4), .memb_write_enable(web4), .memb_write_line(lb4),
      .memb_write_elem(eb4), .memb_read_enable(reb4), .memb_read_elem(rel4b)
   );

   // ---------------- N=8 instance ----------------
   logic        rst8, valid8, ready8, busy8, done8, abort8, awe8, clr8;
   logic [17:0] instr8;
   logic [2:0]  row8, col8, la8, ea8, lb8, eb8;
   logic [7:0]  da8, db8;
   logic        wea8, web8;
   logic [7:0]  rea8, reb8;
   logic [23:0] rel8a, rel8b;

   tpu_sequencer #(.N(8), .DATA_WIDTH(8), .DRAIN_CYCLES(8)) dut8 (
      .clk(clk), .rst(rst8), .instr_valid(valid8), .instr_ready(ready8),
      .instruction(instr8), .busy(busy8), .done(done8), .aborted(abort8),
      .array_write_enable(awe8), .array_clear(clr8),
      .array_output_row(row8), .array_output_column(col8),
      .mema_data_in(da8), .mema_write_enable(wea8), .mema_write_line(la8),
      .mema_write_elem(ea8), .mema_read_enable(rea8), .mema_read_elem(rel8a),
      .memb_data_in(db8), .memb_write_enable(web8), .memb_write_line(lb8),
      .memb_write_elem(eb8), .memb_read_enable(reb8), .memb_read_elem(rel8b)
   );

   // ---------------- helpers ----------------
   function automatic logic [15:0] mk4(input logic [1:0] op, input logic sel,
         input logic rsv, input logic [1:0] r, input logic [1:0] c, input logic [7:0] imm);
      return {op, sel, rsv, r, c, imm};
   endfunction

   function automatic logic [17:0] mk8(input logic [1:0] op, input logic sel,
         input logic rsv, input logic [2:0] r, input logic [2:0] c, input logic [7:0] imm);
      return {op, sel, rsv, r, c, imm};
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0h required=%0h (cyc %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic push(input bit is8, input int kind, input int c,
                       input int v0, input int v1, input int v2);
      ev_t e;
      e.kind = kind; e.cyc = c; e.v0 = v0; e.v1 = v1; e.v2 = v2;
      if (is8) sb8.push_back(e);
      else     sb4.push_back(e);
   endtask

   task automatic score(input bit is8, input int kind, input int v0, input int v1, input int v2);
      ev_t e;
      checks++;
      if ((is8 && sb8.size() == 0) || (!is8 && sb4.size() == 0)) begin
         failures++;
         $display("FAIL sb%0d unexpected event kind=%0d cyc=%0d got=%0h/%0h/%0h required=none",
                  is8 ? 8 : 4, kind, cyc, v0, v1, v2);
      end else begin
         e = is8 ? sb8.pop_front() : sb4.pop_front();
         if (e.kind != kind || e.cyc != cyc || e.v0 != v0 || e.v1 != v1 || e.v2 != v2) begin
            failures++;
            $display("FAIL sb%0d event got kind=%0d cyc=%0d v=%0h/%0h/%0h required kind=%0d cyc=%0d v=%0h/%0h/%0h",
                     is8 ? 8 : 4, kind, cyc, v0, v1, v2, e.kind, e.cyc, e.v0, e.v1, e.v2);
         end
      end
   endtask

   // ---------------- monitors ----------------
   logic [1:0] prev_row4 = '0, prev_col4 = '0;
   logic [2:0] prev_row8 = '0, prev_col8 = '0;
   int feed8_cnt = 0, feed8_first = -1, feed8_last = -1;

   always @(negedge clk) begin
      if (mon_on) begin
         if (clr4) score(1'b0, K_CLEAR, int'(busy4), int'(|rea4), 0);
         if (rea4 != 0 || reb4 != 0)
            score(1'b0, K_FEED, int'(rea4), int'(rel4a),
                  int'({rea4 == reb4, rel4a == rel4b, busy4, awe4}));
         if (wea4) score(1'b0, K_WRA, int'(da4), int'(la4), int'(ea4));
         if (web4) score(1'b0, K_WRB, int'(db4), int'(lb4), int'(eb4));
         if (done4) score(1'b0, K_DONE, int'(busy4), int'(ready4), 0);
         if (abort4) score(1'b0, K_ABORT, int'(busy4), int'(awe4), int'(rea4));
         if (row4 != prev_row4 || col4 != prev_col4)
            score(1'b0, K_RSEL, int'(row4), int'(col4), 0);

         if (clr8) score(1'b1, K_CLEAR, int'(busy8), int'(|rea8), 0);
         if (wea8) score(1'b1, K_WRA, int'(da8), int'(la8), int'(ea8));
         if (web8) score(1'b1, K_WRB, int'(db8), int'(lb8), int'(eb8));
         if (done8) score(1'b1, K_DONE, int'(busy8), int'(ready8), 0);
         if (abort8) score(1'b1, K_ABORT, int'(busy8), int'(awe8), int'(rea8));
         if (row8 != prev_row8 || col8 != prev_col8)
            score(1'b1, K_RSEL, int'(row8), int'(col8), 0);
         if (rea8 != 0) begin
            feed8_cnt++;
            if (feed8_first < 0) feed8_first = cyc;
            feed8_last = cyc;
         end
      end
      prev_row4 = row4; prev_col4 = col4;
      prev_row8 = row8; prev_col8 = col8;
   end

   // ---------------- drivers ----------------
   task automatic issue4(input logic [15:0] ins, output int e_acc);
      int n;
      valid4 = 1'b1; instr4 = ins; #1;
      e_acc = -1; n = 0;
      while (!ready4 && n < 50) begin @(negedge clk); n++; end
      if (!ready4) begin
         checks++; failures++;
         $display("FAIL issue4_timeout got=ready0 required=ready1 instr=%0h", ins);
         valid4 = 1'b0;
      end else begin
         e_acc = cyc + 1;
         @(posedge clk); #1;
         valid4 = 1'b0;
      end
   endtask

   task automatic issue8(input logic [17:0] ins, output int e_acc);
      int n;
      valid8 = 1'b1; instr8 = ins; #1;
      e_acc = -1; n = 0;
      while (!ready8 && n < 50) begin @(negedge clk); n++; end
      if (!ready8) begin
         checks++; failures++;
         $display("FAIL issue8_timeout got=ready0 required=ready1 instr=%0h", ins);
         valid8 = 1'b0;
      end else begin
         e_acc = cyc + 1;
         @(posedge clk); #1;
         valid8 = 1'b0;
      end
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic push_feeds4(input int e, input int nf);
      for (int k = 1; k <= nf; k++) push(1'b0, K_FEED, e + k, feed_en[k-1], feed_el[k-1], 15);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog got=no_finish required=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      int e, e2, es;
      rst4 = 1'b1; rst8 = 1'b1;
      valid4 = 1'b0; valid8 = 1'b0; instr4 = '0; instr8 = '0;
      repeat (3) @(posedge clk);
      #1; rst4 = 1'b0; rst8 = 1'b0;
      @(negedge clk);
      chk("rst_ctrl", int'({busy4, done4, abort4, awe4, clr4, wea4, web4}), 0);
      chk("rst_rdsel", int'({row4, col4}), 0);
      chk("rst_mema", int'({da4, la4, ea4}), 0);
      chk("rst_memb", int'({db4, lb4, eb4}), 0);
      chk("rst_read", int'({rea4, reb4, rel4a, rel4b}), 0);
      chk("rst_ready", int'(ready4), 1);
      mon_on = 1'b1;

      // LOAD A then back-to-back LOAD B
      issue4(mk4(S_OP_LOAD, 1'b0, 1'b0, 2'd2, 2'd3, 8'h5A), e);
      push(1'b0, K_WRA, e, 'h5A, 2, 3);
      issue4(mk4(S_OP_LOAD, 1'b1, 1'b0, 2'd1, 2'd0, 8'hC3), e2);
      push(1'b0, K_WRB, e2, 'hC3, 1, 0);
      chk("b2b_load_edge", e2, e + 1);
      @(negedge clk);
      chk("mema_hold", int'({da4, la4, ea4}), int'({8'h5A, 2'd2, 2'd3}));

      // START mode=0: clear, 7 feeds, done 12 cycles after acceptance
      issue4(mk4(S_OP_START, 1'b0, 1'b0, 2'd0, 2'd0, 8'h00), e);
      push(1'b0, K_CLEAR, e, 1, 0, 0);
      push_feeds4(e, 7);
      push(1'b0, K_DONE, e + 12, 0, 1, 0);
      wait_cyc(e + 15);

      // START mode=1: identical schedule without clear
      issue4(mk4(S_OP_START, 1'b1, 1'b0, 2'd0, 2'd0, 8'h00), e);
      push_feeds4(e, 7);
      push(1'b0, K_DONE, e + 12, 0, 1, 0);
      wait_cyc(e + 15);

      // START, LOAD stalled during RUN, STOP accepted six edges later
      issue4(mk4(S_OP_START, 1'b0, 1'b0, 2'd0, 2'd0, 8'h00), e);
      push(1'b0, K_CLEAR, e, 1, 0, 0);
      push_feeds4(e, 5);
      valid4 = 1'b1; instr4 = mk4(S_OP_LOAD, 1'b0, 1'b0, 2'd3, 2'd0, 8'h42);
      for (int j = 0; j < 5; j++) begin
         @(posedge clk); #1;
         chk("run_load_stall_ready", int'(ready4), 0);
      end
      issue4(mk4(S_OP_STOP, 1'b0, 1'b0, 2'd0, 2'd0, 8'h00), es);
      push(1'b0, K_ABORT, es, 0, 0, 0);
      chk("stop_edge", es, e + 6);
      issue4(mk4(S_OP_LOAD, 1'b0, 1'b0, 2'd3, 2'd0, 8'h42), e2);
      push(1'b0, K_WRA, e2, 'h42, 3, 0);
      chk("load_after_stop_edge", e2, es + 1);
      wait_cyc(e + 16);

      // STOP during DRAIN
      issue4(mk4(S_OP_START, 1'b1, 1'b0, 2'd0, 2'd0, 8'h00), e);
      push_feeds4(e, 7);
      repeat (9) @(posedge clk);
      #1;
      chk("drain_busy", int'(busy4), 1);
      issue4(mk4(S_OP_STOP, 1'b0, 1'b0, 2'd0, 2'd0, 8'h00), es);
      push(1'b0, K_ABORT, es, 0, 0, 0);
      chk("drain_stop_edge", es, e + 10);
      wait_cyc(e + 16);

      // STORE then LOAD (reserved bit set): readout holds
      issue4(mk4(S_OP_STORE, 1'b0, 1'b0, 2'd1, 2'd2, 8'h00), e);
      push(1'b0, K_RSEL, e, 1, 2, 0);
      issue4(mk4(S_OP_LOAD, 1'b0, 1'b1, 2'd0, 2'd1, 8'h3C), e2);
      push(1'b0, K_WRA, e2, 'h3C, 0, 1);
      @(negedge clk); @(negedge clk);
      chk("rdsel_hold", int'({row4, col4}), int'({2'd1, 2'd2}));
      chk("memb_hold", int'({db4, lb4, eb4}), int'({8'hC3, 2'd1, 2'd0}));

      // STOP while IDLE is a no-op
      issue4(mk4(S_OP_STOP, 1'b0, 1'b0, 2'd0, 2'd0, 8'h00), e);
      wait_cyc(e + 4);
      chk("idle_stop_busy", int'(busy4), 0);

      // ---------------- N=8 ----------------
      issue8(mk8(S_OP_LOAD, 1'b0, 1'b0, 3'd5, 3'd6, 8'h77), e);
      push(1'b1, K_WRA, e, 'h77, 5, 6);
      issue8(mk8(S_OP_LOAD, 1'b1, 1'b0, 3'd7, 3'd1, 8'h99), e);
      push(1'b1, K_WRB, e, 'h99, 7, 1);
      issue8(mk8(S_OP_STORE, 1'b0, 1'b0, 3'd3, 3'd4, 8'h00), e);
      push(1'b1, K_RSEL, e, 3, 4, 0);

      feed8_cnt = 0; feed8_first = -1; feed8_last = -1;
      issue8(mk8(S_OP_START, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00), e);
      push(1'b1, K_CLEAR, e, 1, 0, 0);
      push(1'b1, K_DONE, e + 24, 0, 1, 0);
      wait_cyc(e + 27);
      chk("n8_feed_len", feed8_cnt, 15);
      chk("n8_feed_first", feed8_first, e + 1);
      chk("n8_feed_last", feed8_last, e + 15);

      // reset asserted for one edge in the middle of DRAIN
      feed8_cnt = 0;
      issue8(mk8(S_OP_START, 1'b1, 1'b0, 3'd0, 3'd0, 8'h00), e);
      repeat (17) @(posedge clk);
      #1;
      chk("n8_pre_rst_busy", int'(busy8), 1);
      push(1'b1, K_RSEL, e + 18, 0, 0, 0);
      rst8 = 1'b1;
      @(posedge clk); #1;
      rst8 = 1'b0;
      @(negedge clk);
      chk("n8_rst_cyc", cyc, e + 18);
      chk("n8_rst_ctrl", int'({busy8, done8, abort8, awe8, clr8, wea8, web8}), 0);
      chk("n8_rst_mema", int'({da8, la8, ea8}), 0);
      chk("n8_rst_memb", int'({db8, lb8, eb8}), 0);
      chk("n8_rst_read", int'({rea8, reb8}), 0);
      chk("n8_rst_elem", int'(|{rel8a, rel8b}), 0);
      chk("n8_rst_ready", int'(ready8), 1);
      wait_cyc(e + 32);
      chk("n8_feed_len_mode1", feed8_cnt, 15);

      chk("sb4_drained", sb4.size(), 0);
      chk("sb8_drained", sb8.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
